// File: rtl/vec_st_if.sv
// Memory write channel between the vector store unit and the memory side.
// The LSU (master) drives address, data and write request; memory (slave) returns the ack.
interface vec_st_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SEW  = 32
);
    logic [XLEN-1:0] lsu2mem_addr;
    logic [SEW-1:0]  lsu2mem_data;
    logic            lsu2mem_we;
    logic            mem2lsu_ack;

    modport master (
        output lsu2mem_addr,
        output lsu2mem_data,
        output lsu2mem_we,
        input  mem2lsu_ack
    );

    modport slave (
        input  lsu2mem_addr,
        input  lsu2mem_data,
        input  lsu2mem_we,
        output mem2lsu_ack
    );
endinterface

// File: rtl/vec_st_unit.sv
// Vector store unit: writes VLMAX elements of a captured vector register group to memory,
// one element per accepted write, at base + i*stride.
// Optional feature: define VEC_ST_MASK_EN to add a per-element write mask input (vmask).
// Masked-off elements spend one STORE cycle with we=0 and still advance the address.
module vec_st_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned VLEN  = 512,
    parameter int unsigned SEW   = 32,
    parameter int unsigned LMUL  = 1,
    parameter int unsigned VLMAX = (VLEN / SEW) * LMUL
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 st_inst,
    input  logic                 stride_sel,
    input  logic [XLEN-1:0]      rs1_data,
    input  logic [XLEN-1:0]      rs2_data,
    input  logic [VLEN*LMUL-1:0] vs3_data,
`ifdef VEC_ST_MASK_EN
    input  logic [VLMAX-1:0]     vmask,
`endif
    vec_st_if.master             mem,
    output logic                 busy,
    output logic                 is_stored
);

    localparam int unsigned VW = VLEN * LMUL;
    localparam int unsigned CW = $clog2(VLMAX) + 1;
    localparam logic [XLEN-1:0] UnitStride = XLEN'(SEW / 8);
    localparam logic [CW-1:0]   LastIdx    = CW'(VLMAX - 1);

    typedef enum logic [1:0] {StIdle, StStore, StDone} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [VW-1:0]     vec_q, vec_d;
    logic [VLMAX-1:0]  mask_q, mask_d;
    logic [XLEN-1:0]   stride_q, stride_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [SEW-1:0]    data_q, data_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [VLMAX-1:0]  mask_in;
    logic [CW-1:0]     nxt;
    logic [VW-1:0]     vec_sh;
    logic [VLMAX-1:0]  mask_sh;
    logic              advance;

`ifdef VEC_ST_MASK_EN
    assign mask_in = vmask;
`else
    assign mask_in = '1;
`endif

    // A masked-off element (we_q low in STORE) moves on without waiting for an ack.
    assign advance = mem.mem2lsu_ack || !we_q;

    // Next-state and next-output logic; outputs are registered so they change only on edges.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        vec_d    = vec_q;
        mask_d   = mask_q;
        stride_d = stride_q;
        addr_d   = addr_q;
        data_d   = data_q;
        we_d     = we_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        nxt      = cnt_q + CW'(1);
        vec_sh   = vec_q >> (nxt * SEW);
        mask_sh  = mask_q >> nxt;

        unique case (state_q)
            StIdle: begin
                if (st_inst) begin
                    state_d  = StStore;
                    cnt_d    = '0;
                    vec_d    = vs3_data;
                    mask_d   = mask_in;
                    stride_d = stride_sel ? UnitStride : rs2_data;
                    addr_d   = rs1_data;
                    data_d   = vs3_data[SEW-1:0];
                    we_d     = mask_in[0];
                    busy_d   = 1'b1;
                end
            end
            StStore: begin
                if (advance) begin
                    if (cnt_q == LastIdx) begin
                        state_d = StDone;
                        addr_d  = '0;
                        data_d  = '0;
                        we_d    = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d  = nxt;
                        addr_d = addr_q + stride_q;
                        data_d = vec_sh[SEW-1:0];
                        we_d   = mask_sh[0];
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                we_d    = 1'b0;
                addr_d  = '0;
                data_d  = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            vec_q    <= '0;
            mask_q   <= '0;
            stride_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            vec_q    <= vec_d;
            mask_q   <= mask_d;
            stride_q <= stride_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            we_q     <= we_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign mem.lsu2mem_addr = addr_q;
    assign mem.lsu2mem_data = data_q;
    assign mem.lsu2mem_we   = we_q;
    assign busy             = busy_q;
    assign is_stored        = done_q;

endmodule

// File: doc/vec_st_unit.md
VEC_ST_UNIT -- requirements
Module: vec_st_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, scalar address/data width.
REQ-002 SHALL have parameter VLEN, default 512, bits per vector register.
REQ-003 SHALL have parameter SEW, default 32, bits per element.
REQ-004 SHALL have parameter LMUL, default 1, register grouping.
REQ-005 SHALL have parameter VLMAX, default (VLEN/SEW)*LMUL, elements per store.
REQ-006 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-007 SHALL have port n_rst  input  1  reset, synchronous and active-low.
REQ-008 SHALL have port st_inst  input  1  start pulse for a vector store.
REQ-009 SHALL have port stride_sel  input  1  1 = unit stride (SEW/8 bytes), 0 = stride rs2_data.
REQ-010 SHALL have port rs1_data  input  XLEN  base address.
REQ-011 SHALL have port rs2_data  input  XLEN  constant stride in bytes.
REQ-012 SHALL have port vs3_data  input  VLEN*LMUL  source vector; element i = bits [i*SEW +: SEW].
REQ-013 SHALL have port lsu2mem_addr  output  XLEN  write address.
REQ-014 SHALL have port lsu2mem_data  output  SEW  write data.
REQ-015 SHALL have port lsu2mem_we  output  1  write request.
REQ-016 SHALL have port mem2lsu_ack  input  1  memory accepted current write.
REQ-017 SHALL have port busy  output  1  store in progress.
REQ-018 SHALL have port is_stored  output  1  one-cycle pulse, all elements done.

Function
REQ-019 SHALL implement FSM states IDLE, STORE, DONE.
REQ-020 SHALL, in IDLE with st_inst=1, capture vs3_data, rs1_data, effective stride (SEW/8 or rs2_data), clear element counter, go to STORE next cycle.
REQ-021 SHALL ignore st_inst while in STORE or DONE; captured operands stay unchanged.
REQ-022 SHALL, in STORE, drive lsu2mem_we=1, lsu2mem_addr = base + i*stride (mod 2^XLEN), lsu2mem_data = element i of the captured vector.
REQ-023 SHALL hold addr, data, we stable until mem2lsu_ack=1 is sampled; ack in same cycle as first we assertion is legal (one element per cycle max).
REQ-024 SHALL, on ack, advance i by 1 and address by stride via an adder (no multiplier).
REQ-025 SHALL, on ack of element VLMAX-1, go to DONE; DONE asserts is_stored=1 for exactly one cycle, then IDLE.
REQ-026 SHALL ignore mem2lsu_ack outside STORE.
REQ-027 SHALL drive busy=1 in STORE and DONE, 0 in IDLE.
REQ-028 SHALL drive lsu2mem_we=0, lsu2mem_addr=0, lsu2mem_data=0 outside STORE.
REQ-029 SHALL size the element counter $clog2(VLMAX)+1 bits, no wrap before DONE.
REQ-030 SHALL take VLMAX+2 cycles from st_inst to is_stored with ack held high.

Reset
REQ-031 SHALL, while n_rst=0 at a rising clk edge, enter IDLE, clear counter, captured operands and all outputs to 0.
REQ-032 SHALL, on reset mid-store, abandon remaining elements with no is_stored pulse; we=0 from the cycle after the reset edge.

Configuration
REQ-033 SHALL, with macro VEC_ST_MASK_EN defined, add input vmask [VLMAX-1:0] captured with st_inst; element i with mask bit 0 spends one STORE cycle with we=0, ack ignored, address still advances.
REQ-034 SHALL, without VEC_ST_MASK_EN, omit vmask and write every element.

Verification
REQ-035 Unit stride: rs1=0x1000, stride_sel=1, ack always 1 -> 16 writes to 0x1000..0x103C step 4, is_stored at cycle 18.
REQ-036 Strided: rs1=0x2000, rs2=0x10, stride_sel=0 -> addresses 0x2000..0x20F0, data = vs3 elements 0..15 in order.
REQ-037 Backpressure: ack low 3 cycles per element -> addr/data/we stable while stalled, 64 total STORE cycles, one is_stored pulse.
REQ-038 Wrap: rs1=0xFFFFFFF8, unit stride -> element 2 address 0x00000000.
REQ-039 Reset mid-store after element 5 ack -> we=0 next cycle, no is_stored, new st_inst restarts at element 0.
REQ-040 With VEC_ST_MASK_EN, vmask=0x5555 -> only even elements written, 16 STORE cycles with ack=1.
